instruction_fetch_unit: RTL

Fetch front end that initiates reads from the read-only InstructionMemory and delivers instruction words to decode over a valid/ready handshake. It owns the fetch PC and drives the memory `Address` port. It waits a fixed number of cycles for the combinational-but-slow memory read to settle, then captures `Data` into a 2-entry buffer. Execute can redirect it on a taken branch; a redirect flushes all in-flight and buffered fetches.

---
 rtl/instruction_fetch_unit.sv | 138 +++++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: drives the instruction memory address, waits
// RD_CYCLES for the read to settle, buffers up to two {word, pc} entries and
// hands them to decode over valid/ready. A redirect flushes everything.
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int unsigned RD_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        resetl,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_word,
  output logic [63:0] inst_pc,
  output logic [31:0] fetch_count
);

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;
  localparam int unsigned OW = 2;
  localparam logic [CW-1:0] LAST_CNT = CW'(RD_CYCLES - 1);

  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t        r_state, w_state_n;
  logic [AW-1:0] r_pc, w_pc_n;
  logic [CW-1:0] r_wait_cnt, w_wait_cnt_n;
  logic [OW-1:0] r_occ, w_occ_n;
  logic [DW-1:0] r_word0, r_word1, w_word0_n, w_word1_n;
  logic [AW-1:0] r_wpc0, r_wpc1, w_wpc0_n, w_wpc1_n;
  logic [DW-1:0] r_fetch_count, w_fetch_count_n;
  logic          w_pop;
  logic          w_sample;

  // Next-state logic: redirect first, then pop (shift head), then sample (push).
  always_comb begin
    w_state_n       = r_state;
    w_pc_n          = r_pc;
    w_wait_cnt_n    = r_wait_cnt;
    w_occ_n         = r_occ;
    w_word0_n       = r_word0;
    w_word1_n       = r_word1;
    w_wpc0_n        = r_wpc0;
    w_wpc1_n        = r_wpc1;
    w_fetch_count_n = r_fetch_count;
    w_sample        = 1'b0;
    w_pop           = (r_occ != OW'(0)) && inst_ready && !redirect;

    if (redirect) begin
      w_state_n    = ST_WAIT;
      w_pc_n       = {redirect_pc[AW-1:2], 2'b00};
      w_wait_cnt_n = '0;
      w_occ_n      = '0;
      w_word0_n    = '0;
      w_word1_n    = '0;
      w_wpc0_n     = '0;
      w_wpc1_n     = '0;
    end else begin
      // Empty slots are kept at zero so the head reads 0 when invalid.
      if (w_pop) begin
        w_word0_n = r_word1;
        w_wpc0_n  = r_wpc1;
        w_word1_n = '0;
        w_wpc1_n  = '0;
        w_occ_n   = r_occ - OW'(1);
      end

      case (r_state)
        ST_WAIT: begin
          if (r_wait_cnt == LAST_CNT) begin
            if (w_occ_n != OW'(2)) w_sample = 1'b1;
            else                   w_state_n = ST_HOLD;
          end else begin
            w_wait_cnt_n = r_wait_cnt + CW'(1);
          end
        end
        ST_HOLD: begin
          if (w_pop) w_sample = 1'b1;
        end
        default: w_state_n = ST_WAIT;
      endcase

      if (w_sample) begin
        if (w_occ_n == OW'(0)) begin
          w_word0_n = imem_data;
          w_wpc0_n  = r_pc;
        end else begin
          w_word1_n = imem_data;
          w_wpc1_n  = r_pc;
        end
        w_occ_n         = w_occ_n + OW'(1);
        w_pc_n          = r_pc + AW'(4);
        w_wait_cnt_n    = '0;
        w_fetch_count_n = r_fetch_count + DW'(1);
        w_state_n       = ST_WAIT;
      end
    end
  end

  // State and buffer registers with asynchronous reset.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      r_state       <= ST_WAIT;
      r_pc          <= RESET_PC;
      r_wait_cnt    <= '0;
      r_occ         <= '0;
      r_word0       <= '0;
      r_word1       <= '0;
      r_wpc0        <= '0;
      r_wpc1        <= '0;
      r_fetch_count <= '0;
    end else begin
      r_state       <= w_state_n;
      r_pc          <= w_pc_n;
      r_wait_cnt    <= w_wait_cnt_n;
      r_occ         <= w_occ_n;
      r_word0       <= w_word0_n;
      r_word1       <= w_word1_n;
      r_wpc0        <= w_wpc0_n;
      r_wpc1        <= w_wpc1_n;
      r_fetch_count <= w_fetch_count_n;
    end
  end

  assign imem_addr   = r_pc;
  assign inst_valid  = (r_occ != OW'(0));
  assign inst_word   = r_word0;
  assign inst_pc     = r_wpc0;
  assign fetch_count = r_fetch_count;

endmodule
